multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle control FSM for the RV32I datapath. It replaces the tied-high pc_write/ir_write and the
//  purely combinational strobes with a sequenced FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK flow.
//  It handles wait states on instruction and data memory, traps on illegal opcodes or memory timeouts,
//  and counts retired instructions. It sits between the instruction register/ALU flags and the
//  PC, register-file, memory and mux selects.
// PARAMETERS
//  MAX_WAIT    16   max cycles a ready handshake may stall before TRAP (>=1)
//  CNT_W       32   width of retired-instruction counter
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-high reset
//  opcode        in   7      instruction[6:0] from instruction register
//  branch_cond   in   1      branch condition from ALU compare (1 = take)
//  imem_ready    in   1      instruction memory data valid this cycle
//  dmem_ready    in   1      data memory access complete this cycle
//  pc_write      out  1      PC load strobe
//  ir_write      out  1      instruction register load strobe
//  reg_write     out  1      register-file write strobe
//  mem_read      out  1      data memory read request
//  mem_write     out  1      data memory write request
//  alu_src       out  2      [0]=1 op1 is PC, [1]=1 op2 is immediate
//  mem_to_reg    out  2      0 imm, 1 alu, 2 pc+4, 3 mem data
//  pc_src        out  1      0 pc+4, 1 alu_result
//  trap          out  1      sticky; halted until reset
//  trap_cause    out  2      0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
//  instret       out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset: state=FETCH; all strobes 0; trap=0; trap_cause=0; instret=0; wait counter=0.
//  - Strobes are decoded from the registered state and opcode. No strobe is asserted in a reset cycle.
//  - FETCH: ir_write=imem_ready. On ready go to DECODE; otherwise stay.
//  - DECODE: no strobes. An illegal opcode goes to TRAP with cause 1. Otherwise go to EXECUTE.
//    Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
//  - EXECUTE: alu_src is set per class: R=00, I/LOAD/STORE/JALR=10, BRANCH/JAL/AUIPC=11, LUI=xx.
//    BRANCH: pc_write=1, pc_src=branch_cond, then FETCH (retires). LOAD/STORE go to MEMORY.
//    All other classes go to WRITEBACK.
//  - MEMORY: mem_read (LOAD) or mem_write (STORE) is held with alu_src=10 until dmem_ready.
//    STORE on ready: pc_write=1, pc_src=0, then FETCH (retires). LOAD on ready goes to WRITEBACK.
//  - WRITEBACK: reg_write=1 and pc_write=1. pc_src=1 for JAL/JALR, else 0.
//    mem_to_reg: LUI=0, R/I/AUIPC=1, JAL/JALR=2, LOAD=3. alu_src is held as in EXECUTE. Then FETCH.
//  - Per-instruction cycles: BRANCH 3, ALU/jump 4, STORE 4+w, LOAD 5+w (w = dmem wait cycles).
//    Fetch stall adds imem wait cycles.
//  - Wait counter: cleared on every state change.
//    It increments each FETCH/MEMORY cycle while ready=0.
//    If ready is still 0 when the counter reaches MAX_WAIT, go to TRAP (cause 2 or 3). Ready in that
//    same cycle wins, so there is no trap.
//  - TRAP: all strobes 0; trap=1; trap_cause is held; the state stays until reset.
//  - instret increments on every pc_write cycle and wraps modulo 2^CNT_W. It does not increment in TRAP.
//  - Reset mid-operation (e.g. during MEMORY with mem_write high) drops all strobes on the next edge.
//    No partial retire is counted.
//  - opcode must stay stable from DECODE through retire; the IR is only loaded in FETCH.
// STRUCTURE
//  - rv32_ctrl_pkg holds: state_t enum (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP);
//    OPC_* opcode localparams; MTR_* mem_to_reg and TRAP_* cause encodings.
//  - Sub-module wait_timer (clear, tick, expired; MAX_WAIT param) is shared by FETCH and MEMORY.
//  - FSM next-state and output decode are in one always_comb; state, trap and instret are in always_ff.
// TESTING
//  - ADDI (0010011), ready always 1 -> ir_write@c0, pc_write+reg_write@c3, mem_to_reg=1, instret=1.
//  - BEQ taken, branch_cond=1 -> pc_write=1 and pc_src=1 in EXECUTE, no reg_write, 3 cycles.
//    Not taken -> pc_src=0.
//  - LW with dmem_ready low 3 cycles -> mem_read high 4 cycles, then WRITEBACK with mem_to_reg=3.
//    Total 8 cycles, instret+1.
//  - SW, dmem_ready never high, MAX_WAIT=16 -> trap=1, trap_cause=3 after 16 MEMORY cycles.
//    mem_write then 0; stays halted.
//  - Opcode 0000000 -> TRAP cause 1 at DECODE+1. reset=1 one cycle -> FETCH, trap=0, instret=0.
//  - Run JAL loop 2^CNT_W times with CNT_W=4 -> instret wraps 15->0. Reset asserted mid-MEMORY -> mem_write=0 next cycle.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control FSM.
// Opcode classification lives here so the FSM only ever reasons about classes.
package rv32_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_ILLEGAL
  } opclass_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] MTR_IMM = 2'd0;
  localparam logic [1:0] MTR_ALU = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;
  localparam logic [1:0] MTR_MEM = 2'd3;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_IMEM    = 2'd2;
  localparam logic [1:0] TRAP_DMEM    = 2'd3;

  function automatic opclass_t classify(input logic [6:0] opc);
    opclass_t cls;
    case (opc)
      OPC_OP:     cls = CLS_R;
      OPC_OPIMM:  cls = CLS_I;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_controller_wait_timer.sv
// Stall counter shared by the FETCH and MEMORY handshakes.
// expired fires on the stall cycle that brings the count up to MAX_WAIT.
module wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = tick && (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the RV32I datapath,
// with memory wait states, sticky traps and a retired-instruction counter.
module multicycle_controller
  import rv32_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_cond,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       alu_src,
  output logic [1:0]       mem_to_reg,
  output logic             pc_src,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  opclass_t         cls;
  logic [1:0]       exec_src;
  logic             tick, clear, expired;

  assign cls   = classify(opcode);
  assign tick  = ((state_q == FETCH) && !imem_ready) || ((state_q == MEMORY) && !dmem_ready);
  assign clear = (state_d != state_q);

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .tick    (tick),
    .expired (expired)
  );

  always_comb begin
    case (cls)
      CLS_I, CLS_LOAD, CLS_STORE, CLS_JALR: exec_src = 2'b10;
      CLS_BRANCH, CLS_JAL, CLS_AUIPC:       exec_src = 2'b11;
      default:                              exec_src = 2'b00;
    endcase
  end

  // Strobes are forced low while reset is high, whatever state is still registered.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 2'b00;
    mem_to_reg = MTR_IMM;
    pc_src     = 1'b0;
    trap       = 1'b0;
    trap_cause = TRAP_NONE;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            ir_write = 1'b1;
            state_d  = DECODE;
          end else if (expired) begin
            state_d = TRAP;
            cause_d = TRAP_IMEM;
          end
        end
        DECODE: begin
          if (cls == CLS_ILLEGAL) begin
            state_d = TRAP;
            cause_d = TRAP_ILLEGAL;
          end else begin
            state_d = EXECUTE;
          end
        end
        EXECUTE: begin
          alu_src = exec_src;
          case (cls)
            CLS_BRANCH: begin
              pc_write = 1'b1;
              pc_src   = branch_cond;
              state_d  = FETCH;
            end
            CLS_LOAD, CLS_STORE: state_d = MEMORY;
            default:             state_d = WRITEBACK;
          endcase
        end
        MEMORY: begin
          alu_src   = 2'b10;
          mem_read  = (cls == CLS_LOAD);
          mem_write = (cls == CLS_STORE);
          if (dmem_ready) begin
            if (cls == CLS_STORE) begin
              pc_write = 1'b1;
              state_d  = FETCH;
            end else begin
              state_d = WRITEBACK;
            end
          end else if (expired) begin
            state_d = TRAP;
            cause_d = TRAP_DMEM;
          end
        end
        WRITEBACK: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          alu_src   = exec_src;
          pc_src    = (cls == CLS_JAL) || (cls == CLS_JALR);
          case (cls)
            CLS_LUI:            mem_to_reg = MTR_IMM;
            CLS_JAL, CLS_JALR:  mem_to_reg = MTR_PC4;
            CLS_LOAD:           mem_to_reg = MTR_MEM;
            default:            mem_to_reg = MTR_ALU;
          endcase
          state_d = FETCH;
        end
        TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_q;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      cause_q   <= TRAP_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (pc_write) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded into the
// per-cycle strobe trace the controller should produce, given the chosen wait states.
module tb_multicycle_controller;

  localparam int MAXW = 16;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    opcode = 7'd0;
  logic          branch_cond = 1'b0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          pc_write, ir_write, reg_write, mem_read, mem_write, pc_src, trap;
  logic [1:0]    alu_src, mem_to_reg, trap_cause;
  logic [CW-1:0] instret;

  int numVectors = 0;
  int numMiscompares = 0;
  int modelRetired = 0;
  bit modelTrapped = 0;

  logic [6:0] legalOps [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  multicycle_controller #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .branch_cond (branch_cond),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .pc_src      (pc_src),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numVectors++;
    if (observed !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Instruction-class view of the opcode, straight from the ISA tables.
  function automatic bit isLegal(input logic [6:0] opc);
    foreach (legalOps[i]) if (legalOps[i] == opc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int srcOf(input logic [6:0] opc);
    case (opc)
      7'b0110011: return 0;
      7'b0010011, 7'b0000011, 7'b0100011, 7'b1100111: return 2;
      7'b1100011, 7'b1101111, 7'b0010111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int mtrOf(input logic [6:0] opc);
    case (opc)
      7'b0110111: return 0;
      7'b1101111, 7'b1100111: return 2;
      7'b0000011: return 3;
      default: return 1;
    endcase
  endfunction

  // Drive one cycle's inputs, compare outputs mid-cycle, then advance past the edge.
  task automatic stepCycle(input string tag, input logic iRdy, input logic dRdy,
                           input logic eIw, input logic ePw, input logic eRw, input logic eMr,
                           input logic eMw, input logic eTr, input logic [1:0] eCause,
                           input int eSrc, input int eMtr, input int ePcs);
    imem_ready = iRdy;
    dmem_ready = dRdy;
    #1;
    checkOutput({tag, "_strobes"},
                {24'd0, pc_write, ir_write, reg_write, mem_read, mem_write, trap, trap_cause},
                {24'd0, ePw, eIw, eRw, eMr, eMw, eTr, eCause});
    checkOutput({tag, "_instret"}, 32'(instret), 32'(modelRetired % (1 << CW)));
    if (eSrc >= 0) checkOutput({tag, "_alu_src"}, 32'(alu_src), 32'(eSrc));
    if (eMtr >= 0) checkOutput({tag, "_mem_to_reg"}, 32'(mem_to_reg), 32'(eMtr));
    if (ePcs >= 0) checkOutput({tag, "_pc_src"}, 32'(pc_src), 32'(ePcs));
    if (ePw) modelRetired = (modelRetired + 1) % (1 << CW);
    @(posedge clk);
    #1;
  endtask

  task automatic checkTrapped(input logic [1:0] cause);
    modelTrapped = 1'b1;
    for (int n = 0; n < 3; n++) begin
      stepCycle("trap", 1'($urandom), 1'($urandom), 0, 0, 0, 0, 0, 1, cause, -1, -1, -1);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    #1;
    checkOutput("reset_strobes",
                {24'd0, pc_write, ir_write, reg_write, mem_read, mem_write, trap, trap_cause}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    imem_ready = 1'b0;
    modelRetired = 0;
    modelTrapped = 1'b0;
    #1;
    checkOutput("post_reset_strobes",
                {24'd0, pc_write, ir_write, reg_write, mem_read, mem_write, trap, trap_cause}, 32'd0);
    checkOutput("post_reset_instret", 32'(instret), 32'd0);
  endtask

  // One instruction: wi imem stall cycles, wd dmem stall cycles; midMemReset aborts in MEMORY.
  task automatic applyStimulus(input logic [6:0] opc, input logic bc, input int wi, input int wd,
                               input bit midMemReset);
    int src;
    src = srcOf(opc);
    opcode = opc;
    branch_cond = bc;
    for (int k = 0; k < wi && k < MAXW; k++)
      stepCycle("fetch_stall", 0, 1'($urandom), 0, 0, 0, 0, 0, 0, 0, -1, -1, -1);
    if (wi >= MAXW) begin
      checkTrapped(2'd2);
      return;
    end
    stepCycle("fetch", 1, 1'($urandom), 1, 0, 0, 0, 0, 0, 0, -1, -1, -1);
    stepCycle("decode", 1'($urandom), 1'($urandom), 0, 0, 0, 0, 0, 0, 0, -1, -1, -1);
    if (!isLegal(opc)) begin
      checkTrapped(2'd1);
      return;
    end
    if (opc == 7'b1100011) begin
      stepCycle("exec_branch", 1'($urandom), 1'($urandom), 0, 1, 0, 0, 0, 0, 0, src, -1, int'(bc));
      return;
    end
    stepCycle("exec", 1'($urandom), 1'($urandom), 0, 0, 0, 0, 0, 0, 0, src, -1, -1);
    if (opc == 7'b0000011 || opc == 7'b0100011) begin
      for (int k = 0; k < wd && k < MAXW; k++) begin
        if (midMemReset && k == 2) begin
          doReset();
          return;
        end
        stepCycle("mem_stall", 1'($urandom), 0, 0, 0, 0, opc == 7'b0000011, opc == 7'b0100011,
                  0, 0, 2, -1, -1);
      end
      if (wd >= MAXW) begin
        checkTrapped(2'd3);
        return;
      end
      if (opc == 7'b0100011) begin
        stepCycle("mem_store", 1'($urandom), 1, 0, 1, 0, 0, 1, 0, 0, 2, -1, 0);
        return;
      end
      stepCycle("mem_load", 1'($urandom), 1, 0, 0, 0, 1, 0, 0, 0, 2, -1, -1);
    end
    stepCycle("writeback", 1'($urandom), 1'($urandom), 0, 1, 1, 0, 0, 0, 0, src, mtrOf(opc),
              (opc == 7'b1101111 || opc == 7'b1100111) ? 1 : 0);
  endtask

  initial begin
    int r, wi, wd;
    logic [6:0] opc;
    doReset();
    applyStimulus(7'b0010011, 0, 0, 0, 0);
    applyStimulus(7'b1100011, 1, 0, 0, 0);
    applyStimulus(7'b1100011, 0, 2, 0, 0);
    applyStimulus(7'b0000011, 0, 0, 3, 0);
    applyStimulus(7'b0100011, 0, MAXW - 1, MAXW - 1, 0);
    applyStimulus(7'b0100011, 0, 0, MAXW + 4, 0);
    doReset();
    applyStimulus(7'b0000000, 0, 0, 0, 0);
    doReset();
    for (int i = 0; i < (1 << CW) + 1; i++) applyStimulus(7'b1101111, 0, 0, 0, 0);
    applyStimulus(7'b0100011, 0, 0, 6, 1);
    applyStimulus(7'b0010011, 0, MAXW, 0, 0);
    doReset();
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      opc = (r < 4) ? ((r < 2) ? 7'b0000000 : 7'b1111111) : legalOps[$urandom_range(0, 8)];
      wi = ($urandom_range(0, 99) < 3) ? MAXW + $urandom_range(0, 2) : $urandom_range(0, 3);
      wd = ($urandom_range(0, 99) < 3) ? MAXW + $urandom_range(0, 2) : $urandom_range(0, 4);
      applyStimulus(opc, 1'($urandom), wi, wd, 0);
      if (modelTrapped) doReset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
